// File: rtl/vector_recorder_pkg.sv
// vector_recorder shared types and default sizes.
// Trigger logic is built only with VECTOR_RECORDER_TRIGGER_EN defined.
package vector_recorder_pkg;

  localparam int VREC_WIDTH = 5;
  localparam int VREC_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RECORD,
    ST_DONE
  } vrec_state_e;

endpackage

// File: rtl/vector_recorder_if.sv
// vector_recorder control, sample and readout bundle.
// master drives capture/readout requests, slave is the recorder.
interface vector_recorder_if
  import vector_recorder_pkg::*;
#(
  parameter int WIDTH = VREC_WIDTH,
  parameter int DEPTH = VREC_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) ();

  logic             arm;
  logic             stop;
  logic             sample_valid;
  logic [WIDTH-1:0] sample_data;
  logic [WIDTH-1:0] trig_value;
  logic [WIDTH-1:0] trig_mask;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [AW:0]      count;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output arm, stop, sample_valid, sample_data,
    output trig_value, trig_mask, rd_en, rd_addr,
    input  rd_data, rd_valid, count, busy, done, overflow
  );

  modport slave (
    input  arm, stop, sample_valid, sample_data,
    input  trig_value, trig_mask, rd_en, rd_addr,
    output rd_data, rd_valid, count, busy, done, overflow
  );

endinterface

// File: rtl/vrec_mem.sv
// Vector store: one synchronous write port, one synchronous read port.
// No reset; contents survive across captures.
module vrec_mem #(
  parameter int WIDTH = 5,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
  logic [WIDTH-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port, data one cycle after request
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_recorder.sv
// vector_recorder: arm/stop capture of sample vectors with readout.
// Define VECTOR_RECORDER_TRIGGER_EN to gate capture start on a masked match.
module vector_recorder
  import vector_recorder_pkg::*;
#(
  parameter int WIDTH = VREC_WIDTH,
  parameter int DEPTH = VREC_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              reset,
  vector_recorder_if.slave bus
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  vrec_state_e state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        rdv_q;
  logic        we;
  logic        rd_hit;
  logic        trig_ok;
  logic        stop_ok;
  logic        full;
  logic [WIDTH-1:0] mem_rdata;

`ifdef VECTOR_RECORDER_TRIGGER_EN
  assign trig_ok =
    ((bus.sample_data ^ bus.trig_value) & bus.trig_mask) == '0;
`else
  logic unused_trig;
  assign unused_trig = ^{bus.trig_value, bus.trig_mask};
  assign trig_ok = 1'b1;
`endif

  assign full    = (count_q == FULL);
  assign stop_ok = bus.stop && !bus.arm;

  // Next-state and capture write decision
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          state_d = ST_ARMED;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (bus.sample_valid && trig_ok) begin
          we      = 1'b1;
          count_d = count_q + ONE;
          state_d = ST_RECORD;
        end
        if (stop_ok) state_d = ST_DONE;
      end
      ST_RECORD: begin
        if (bus.sample_valid && !full) begin
          we      = 1'b1;
          count_d = count_q + ONE;
          if (count_q == FULL - ONE) state_d = ST_DONE;
        end
        if (stop_ok) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.arm) begin
          state_d = ST_ARMED;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (bus.sample_valid && full) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_hit = bus.rd_en
               && (state_q == ST_IDLE || state_q == ST_DONE)
               && ({1'b0, bus.rd_addr} < count_q);

  // State, count, overflow and readout-valid registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rdv_q   <= rd_hit;
    end
  end

  vrec_mem #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (bus.sample_data),
    .re_i    (rd_hit),
    .raddr_i (bus.rd_addr),
    .rdata_o (mem_rdata)
  );

  assign bus.rd_valid = rdv_q;
  assign bus.rd_data  = rdv_q ? mem_rdata : '0;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q == ST_ARMED) || (state_q == ST_RECORD);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.overflow = ovf_q;

endmodule
